// File: rtl/maxpool_ctrl.sv
// Sequencer for the 2x2 max-pool unit.
// Walks non-overlapping 2x2 windows of a feature map in raster order. For each window it:
//   - reads the four pixels from a synchronous RAM,
//   - presents them to the pool unit and waits one cycle for its registered result,
//   - writes the pooled value to the output RAM, holding the write until it is accepted.
module maxpool_ctrl #(
    parameter int DATA_W  = 16,
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int IADDR_W = 10,
    parameter int OADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [IADDR_W-1:0]    rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    output logic [4*DATA_W-1:0]   pool_win,
    input  logic [DATA_W-1:0]     pool_res,
    output logic                  wr_en,
    output logic [OADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_ready
);

    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;
    localparam int CW = (OW > 1) ? $clog2(OW) : 1;
    localparam int RW = (OH > 1) ? $clog2(OH) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, POOL, WRITE, DONE} state_t;

    state_t                     state_reg;
    logic [1:0]                 k_reg;
    logic [CW-1:0]              col_reg;
    logic [RW-1:0]              row_reg;
    logic [IADDR_W-1:0]         row_start_reg;
    logic [3:0][DATA_W-1:0]     win_reg;
    logic [DATA_W-1:0]          wr_data_reg;
    logic                       write_first_reg;
    logic                       busy_reg;
    logic                       done_reg;
    logic                       rd_en_reg;
    logic [IADDR_W-1:0]         rd_addr_reg;
    logic                       wr_en_reg;
    logic [OADDR_W-1:0]         wr_addr_reg;

    logic [IADDR_W-1:0]         win_base;
    logic [IADDR_W-1:0]         fetch_addr_next;
    logic [IADDR_W-1:0]         next_base;
    logic [1:0]                 k_next;
    logic                       last_col;
    logic                       last_row;

    // Window base address, address of the next pixel to fetch, and base of the next window
    always_comb begin
        win_base        = row_start_reg + (IADDR_W'(col_reg) << 1);
        k_next          = k_reg + 2'd1;
        fetch_addr_next = win_base + (k_next[1] ? IADDR_W'(IMG_W) : '0) + IADDR_W'(k_next[0]);
        last_col        = (col_reg == CW'(OW - 1));
        last_row        = (row_reg == RW'(OH - 1));
        next_base       = last_col ? (row_start_reg + IADDR_W'(2 * IMG_W))
                                   : (win_base + IADDR_W'(2));
    end

    // Main FSM with all control outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            k_reg           <= '0;
            col_reg         <= '0;
            row_reg         <= '0;
            row_start_reg   <= '0;
            win_reg         <= '0;
            wr_data_reg     <= '0;
            write_first_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            rd_en_reg       <= 1'b0;
            rd_addr_reg     <= '0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg     <= FETCH;
                        busy_reg      <= 1'b1;
                        k_reg         <= '0;
                        col_reg       <= '0;
                        row_reg       <= '0;
                        row_start_reg <= '0;
                        wr_addr_reg   <= '0;
                        rd_en_reg     <= 1'b1;
                        rd_addr_reg   <= '0;
                    end
                end
                FETCH: begin
                    // Data for the pixel issued last cycle arrives now
                    if (k_reg != 2'd0) begin
                        win_reg[k_reg - 2'd1] <= rd_data;
                    end
                    if (k_reg == 2'd3) begin
                        rd_en_reg <= 1'b0;
                        state_reg <= LOAD;
                    end else begin
                        k_reg       <= k_next;
                        rd_addr_reg <= fetch_addr_next;
                    end
                end
                LOAD: begin
                    win_reg[3] <= rd_data;
                    state_reg  <= POOL;
                end
                POOL: begin
                    // Pool unit registers the complete window on this edge
                    wr_en_reg       <= 1'b1;
                    write_first_reg <= 1'b1;
                    state_reg       <= WRITE;
                end
                WRITE: begin
                    // pool_res is valid from WRITE entry; hold it for any stall
                    write_first_reg <= 1'b0;
                    if (write_first_reg) begin
                        wr_data_reg <= pool_res;
                    end
                    if (wr_ready) begin
                        wr_en_reg <= 1'b0;
                        if (last_col && last_row) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= DONE;
                        end else begin
                            if (last_col) begin
                                col_reg       <= '0;
                                row_reg       <= row_reg + RW'(1);
                                row_start_reg <= row_start_reg + IADDR_W'(2 * IMG_W);
                            end else begin
                                col_reg <= col_reg + CW'(1);
                            end
                            wr_addr_reg <= wr_addr_reg + OADDR_W'(1);
                            k_reg       <= '0;
                            rd_en_reg   <= 1'b1;
                            rd_addr_reg <= next_base;
                            state_reg   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign rd_en    = rd_en_reg;
    assign rd_addr  = rd_addr_reg;
    assign pool_win = win_reg;
    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = write_first_reg ? pool_res : wr_data_reg;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Testbench for maxpool_ctrl.
// Instance 0 runs a 4x4 map and instance 1 runs a 5x5 map. Each instance gets a
// behavioural input RAM and pool unit, and results are compared against the window-max rule.
module tb_maxpool_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start    [2];
    logic        busy     [2];
    logic        done     [2];
    logic        rd_en    [2];
    logic [9:0]  rd_addr  [2];
    logic [15:0] rd_data  [2];
    logic [63:0] pool_win [2];
    logic [15:0] pool_res [2];
    logic        wr_en    [2];
    logic [7:0]  wr_addr  [2];
    logic [15:0] wr_data  [2];
    logic        wr_ready [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int W = (gi == 0) ? 4 : 5;
            maxpool_ctrl #(.DATA_W(16), .IMG_W(W), .IMG_H(W), .IADDR_W(10), .OADDR_W(8)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .start    (start[gi]),
                .busy     (busy[gi]),
                .done     (done[gi]),
                .rd_en    (rd_en[gi]),
                .rd_addr  (rd_addr[gi]),
                .rd_data  (rd_data[gi]),
                .pool_win (pool_win[gi]),
                .pool_res (pool_res[gi]),
                .wr_en    (wr_en[gi]),
                .wr_addr  (wr_addr[gi]),
                .wr_data  (wr_data[gi]),
                .wr_ready (wr_ready[gi])
            );
        end
    endgenerate

    logic [15:0] mem [2][25];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Logs filled by the monitor
    int          wr_cnt [2];
    int          wlog_a [2][8];
    int          wlog_d [2][8];
    int          done_cnt [2];
    int          busy_cyc [2];
    int          done_cyc [2];
    bit          rd_seen [2][25];
    int          rd_cnt [2];
    int          rd_seq [2][8];
    bit          stall_p [2];
    int          sv_a [2];
    int          sv_d [2];

    function automatic logic [15:0] max4(input logic [63:0] w);
        logic [15:0] m;
        m = w[15:0];
        for (int q = 1; q < 4; q++) if (w[q*16 +: 16] > m) m = w[q*16 +: 16];
        return m;
    endfunction

    // Window j of instance i: max of its 2x2 block in a WxW map
    function automatic int model_win(input int i, input int j);
        int w, ow, r, c, m, v;
        w  = (i == 0) ? 4 : 5;
        ow = w / 2;
        r  = j / ow;
        c  = j % ow;
        m  = 0;
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                v = int'(mem[i][(2*r + dy) * w + 2*c + dx]);
                if (v > m) m = v;
            end
        return m;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Input RAM with one-cycle read latency and pool unit with a registered max
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i] && rd_addr[i] < 10'd25) rd_data[i] <= mem[i][rd_addr[i]];
            pool_res[i] <= max4(pool_win[i]);
        end
    end

    // Monitor sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (busy[i] && busy_cyc[i] < 0) busy_cyc[i] = cyc;
                if (done[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                end
                if (rd_en[i]) begin
                    if (rd_addr[i] < 10'd25) rd_seen[i][rd_addr[i]] = 1'b1;
                    if (rd_cnt[i] < 8) rd_seq[i][rd_cnt[i]] = int'(rd_addr[i]);
                    rd_cnt[i]++;
                end
                if (stall_p[i]) begin
                    chk($sformatf("hold_wr_en[%0d]", i), int'(wr_en[i]), 1);
                    chk($sformatf("hold_wr_addr[%0d]", i), int'(wr_addr[i]), sv_a[i]);
                    chk($sformatf("hold_wr_data[%0d]", i), int'(wr_data[i]), sv_d[i]);
                end
                if (wr_en[i] && wr_ready[i]) begin
                    if (wr_cnt[i] < 8) begin
                        wlog_a[i][wr_cnt[i]] = int'(wr_addr[i]);
                        wlog_d[i][wr_cnt[i]] = int'(wr_data[i]);
                    end
                    wr_cnt[i]++;
                end
                stall_p[i] = wr_en[i] && !wr_ready[i];
                sv_a[i]    = int'(wr_addr[i]);
                sv_d[i]    = int'(wr_data[i]);
            end
        end
    end

    task automatic clear_logs(input int i);
        wr_cnt[i] = 0; done_cnt[i] = 0; busy_cyc[i] = -1; done_cyc[i] = -1;
        rd_cnt[i] = 0; stall_p[i] = 1'b0;
        for (int a = 0; a < 25; a++) rd_seen[i][a] = 1'b0;
        for (int a = 0; a < 8; a++) rd_seq[i][a] = -1;
    endtask

    task automatic fill(input int i, input int pat);
        for (int a = 0; a < 25; a++)
            case (pat)
                0:       mem[i][a] = 16'(a);
                1:       mem[i][a] = 16'hFFFF;
                2:       mem[i][a] = 16'h0000;
                default: mem[i][a] = 16'($urandom);
            endcase
    endtask

    // One full map: start pulse, optional stall on one window, optional extra start
    task automatic run_job(input int i, input int sw, input int sn, input int rs_at);
        int stalled, t;
        clear_logs(i);
        wr_ready[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
        stalled = 0;
        t = 1;
        while (done_cnt[i] == 0 && t < 400) begin
            start[i] = (t == rs_at);
            if (wr_en[i] && int'(wr_addr[i]) == sw && stalled < sn) begin
                wr_ready[i] = 1'b0;
                stalled++;
            end else begin
                wr_ready[i] = 1'b1;
            end
            @(posedge clk); #1;
            t++;
        end
        start[i] = 1'b0;
        wr_ready[i] = 1'b1;
        chk("done_seen", int'(done_cnt[i] > 0), 1);
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic verify(input int i, input bit use_model, input logic [3:0][15:0] exp, input int lat);
        int w, e;
        w = (i == 0) ? 4 : 5;
        chk("n_writes", wr_cnt[i], 4);
        chk("n_done", done_cnt[i], 1);
        chk("latency", done_cyc[i] - busy_cyc[i], lat);
        chk("n_reads", rd_cnt[i], 16);
        chk("rd0", rd_seq[i][0], 0);
        chk("rd1", rd_seq[i][1], 1);
        chk("rd2", rd_seq[i][2], w);
        chk("rd3", rd_seq[i][3], w + 1);
        for (int j = 0; j < 4; j++) begin
            e = use_model ? model_win(i, j) : int'(exp[j]);
            chk($sformatf("wr_addr_%0d", j), wlog_a[i][j], j);
            chk($sformatf("wr_data_%0d", j), wlog_d[i][j], e);
        end
        for (int a = 0; a < w * w; a++)
            chk($sformatf("read_map_%0d", a), int'(rd_seen[i][a]), int'((a % w) < 4 && (a / w) < 4));
    endtask

    task automatic chk_idle_outputs(input int i);
        chk("rst_busy", int'(busy[i]), 0);
        chk("rst_done", int'(done[i]), 0);
        chk("rst_rd_en", int'(rd_en[i]), 0);
        chk("rst_wr_en", int'(wr_en[i]), 0);
        chk("rst_rd_addr", int'(rd_addr[i]), 0);
        chk("rst_wr_addr", int'(wr_addr[i]), 0);
        chk("rst_wr_data", int'(wr_data[i]), 0);
        chk("rst_pool_win", int'(pool_win[i] != 64'd0), 0);
    endtask

    typedef struct {
        int               inst;
        int               pat;
        int               sw;
        int               sn;
        int               rs_at;
        bit               use_model;
        logic [3:0][15:0] exp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int t, lat;
        bit hit;
        tbl[0] = '{0, 0, -1, 0, -1, 1'b0, {16'd15, 16'd13, 16'd7, 16'd5}};
        tbl[1] = '{0, 0,  1, 3, -1, 1'b0, {16'd15, 16'd13, 16'd7, 16'd5}};
        tbl[2] = '{1, 0, -1, 0, -1, 1'b0, {16'd18, 16'd16, 16'd8, 16'd6}};
        tbl[3] = '{0, 0, -1, 0, 10, 1'b0, {16'd15, 16'd13, 16'd7, 16'd5}};
        tbl[4] = '{0, 1, -1, 0, -1, 1'b0, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}};
        tbl[5] = '{0, 2, -1, 0, -1, 1'b0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        tbl[6] = '{1, 3,  2, 2, -1, 1'b1, '0};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            wr_ready[i] = 1'b1;
            clear_logs(i);
        end
        fill(0, 0);
        fill(1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs(0);
        chk_idle_outputs(1);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            fill(tbl[v].inst, tbl[v].pat);
            run_job(tbl[v].inst, tbl[v].sw, tbl[v].sn, tbl[v].rs_at);
            verify(tbl[v].inst, tbl[v].use_model, tbl[v].exp, 28 + tbl[v].sn);
            $display("vector %0d inst %0d done: compared %0d so far", v, tbl[v].inst, n_cmp);
        end

        // Reset during the FETCH of window 2 (base 8), then a clean rerun
        fill(0, 0);
        clear_logs(0);
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        hit = 1'b0;
        t = 0;
        while (!hit && t < 200) begin
            if (rd_en[0] && rd_addr[0] == 10'd9) hit = 1'b1;
            else begin
                @(posedge clk); #1;
                t++;
            end
        end
        chk("reach_win2", int'(hit), 1);
        chk("writes_before_rst", wr_cnt[0], 2);
        rst = 1'b1;
        #1;
        chk_idle_outputs(0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("no_done_after_abort", done_cnt[0], 0);
        chk("idle_after_abort", int'(busy[0]), 0);
        run_job(0, -1, 0, -1);
        verify(0, 1'b0, {16'd15, 16'd13, 16'd7, 16'd5}, 28);
        $display("reset-abort rerun done: compared %0d so far", n_cmp);

        // Random maps with random stalls on both instances
        for (int n = 0; n < 6; n++) begin
            int i, sw, sn;
            i  = n % 2;
            sw = int'($urandom_range(0, 3));
            sn = int'($urandom_range(0, 4));
            fill(i, 3);
            run_job(i, sw, sn, -1);
            lat = 28 + sn;
            verify(i, 1'b1, '0, lat);
            $display("random %0d inst %0d stall win %0d x%0d: compared %0d so far", n, i, sw, sn, n_cmp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
